// File: rtl/cxu_l1_arbiter_pkg.sv
// Shared CXU types: response status and the arbiter's in-flight tag.
package cxu_l1_arbiter_pkg;

  typedef enum logic [1:0] {
    CXU_OK          = 2'd0,
    CXU_ERROR       = 2'd1,
    CXU_ERROR_STATE = 2'd2,
    CXU_ERROR_FUNC  = 2'd3
  } cxu_status_t;

  localparam int unsigned ARB_MAX_REQS = 16;
  localparam int unsigned ARB_IDX_W    = $clog2(ARB_MAX_REQS);

  typedef struct packed {
    logic                 valid;
    logic [ARB_IDX_W-1:0] idx;
    logic                 local_err;
  } arb_tag_t;

  // True when a w-bit field can encode n distinct values.
  function automatic bit width_fits(input int unsigned w, input int unsigned n);
    return 64'(n) <= (64'd1 << w);
  endfunction

endpackage

// File: rtl/cxu_l1_arbiter_rr.sv
// Round-robin arbiter; the pointer remembers the last grant so the search
// starts just after it.
module cxu_l1_arbiter_rr
  import cxu_l1_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_grant,
  output logic [ARB_IDX_W-1:0] o_idx
);

  logic [ARB_IDX_W-1:0] r_ptr;
  logic [2*N-1:0]       w_dbl;
  logic [N-1:0]         w_rot;
  logic                 w_found;

  // Rotate requests so bit 0 is the requester right after the pointer.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_rot   = N'(w_dbl >> (32'(r_ptr) + 32'd1));
    w_found = 1'b0;
    o_idx   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (i_en && !w_found && w_rot[j]) begin
        w_found = 1'b1;
        o_idx   = ARB_IDX_W'((32'(r_ptr) + 32'd1 + j) % N);
      end
    end
    o_grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_grant[i] = w_found && (32'(o_idx) == i);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= ARB_IDX_W'(N - 1);
    end else if (w_found) begin
      r_ptr <= o_idx;
    end
  end

endmodule

// File: rtl/cxu_l1_arbiter.sv
// Shares one fixed-latency CXU among N_REQS requesters: round-robin grant,
// per-requester state remapping and a tag pipeline that routes each response.
module cxu_l1_arbiter
  import cxu_l1_arbiter_pkg::*;
#(
  parameter int unsigned N_REQS         = 4,
  parameter int unsigned N_STATES_PER   = 2,
  parameter int unsigned CXU_LATENCY    = 2,
  parameter int unsigned CXU_FUNC_ID_W  = 10,
  parameter int unsigned CXU_STATE_ID_W = 1,
  parameter int unsigned DS_STATE_ID_W  = 3,
  parameter int unsigned CXU_DATA_W     = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_clk_en,
  input  logic [N_REQS-1:0]                  i_req_valid,
  output logic [N_REQS-1:0]                  o_req_ready,
  input  logic [N_REQS*CXU_FUNC_ID_W-1:0]    i_req_func,
  input  logic [N_REQS*CXU_STATE_ID_W-1:0]   i_req_state,
  input  logic [N_REQS*CXU_DATA_W-1:0]       i_req_data0,
  input  logic [N_REQS*CXU_DATA_W-1:0]       i_req_data1,
  output logic [N_REQS-1:0]                  o_resp_valid,
  output cxu_status_t                        o_resp_status,
  output logic [CXU_DATA_W-1:0]              o_resp_data,
  output logic                               o_ds_req_valid,
  output logic [CXU_FUNC_ID_W-1:0]           o_ds_req_func,
  output logic [DS_STATE_ID_W-1:0]           o_ds_req_state,
  output logic [CXU_DATA_W-1:0]              o_ds_req_data0,
  output logic [CXU_DATA_W-1:0]              o_ds_req_data1,
  input  logic                               i_ds_resp_valid,
  input  cxu_status_t                        i_ds_resp_status,
  input  logic [CXU_DATA_W-1:0]              i_ds_resp_data
);

  localparam int unsigned N_DS_STATES = N_REQS * N_STATES_PER;

  if (N_REQS < 2 || N_REQS > ARB_MAX_REQS) begin : g_chk_nreqs
    $error("cxu_l1_arbiter: N_REQS must be in 2..16");
  end
  if (!width_fits(DS_STATE_ID_W, N_DS_STATES)) begin : g_chk_ds_w
    $error("cxu_l1_arbiter: DS_STATE_ID_W too narrow");
  end
  if (!width_fits(CXU_STATE_ID_W, N_STATES_PER)) begin : g_chk_st_w
    $error("cxu_l1_arbiter: CXU_STATE_ID_W too narrow");
  end

  logic [N_REQS-1:0]         w_grant;
  logic [ARB_IDX_W-1:0]      w_gidx;
  logic                      w_any;
  logic                      w_local_err;
  logic [CXU_FUNC_ID_W-1:0]  w_func;
  logic [CXU_STATE_ID_W-1:0] w_state;
  logic [CXU_DATA_W-1:0]     w_d0;
  logic [CXU_DATA_W-1:0]     w_d1;
  arb_tag_t                  w_tag_in;
  arb_tag_t                  w_tag_out;
  logic                      w_ds_expect;

  // Grants are suppressed while clock-enable is low or reset is held.
  cxu_l1_arbiter_rr #(.N(N_REQS)) u_rr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_clk_en & ~i_rst),
    .i_req  (i_req_valid),
    .o_grant(w_grant),
    .o_idx  (w_gidx)
  );

  assign o_req_ready = w_grant;
  assign w_any       = |w_grant;

  always_comb begin
    w_func  = '0;
    w_state = '0;
    w_d0    = '0;
    w_d1    = '0;
    for (int unsigned i = 0; i < N_REQS; i++) begin
      if (w_grant[i]) begin
        w_func  = i_req_func[i*CXU_FUNC_ID_W +: CXU_FUNC_ID_W];
        w_state = i_req_state[i*CXU_STATE_ID_W +: CXU_STATE_ID_W];
        w_d0    = i_req_data0[i*CXU_DATA_W +: CXU_DATA_W];
        w_d1    = i_req_data1[i*CXU_DATA_W +: CXU_DATA_W];
      end
    end
  end

  // Out-of-range private state IDs never reach the CXU; they answer locally.
  assign w_local_err    = w_any && (32'(w_state) >= N_STATES_PER);
  assign o_ds_req_valid = w_any && !w_local_err;
  assign o_ds_req_func  = w_func;
  assign o_ds_req_state = DS_STATE_ID_W'(32'(w_gidx) * N_STATES_PER + 32'(w_state));
  assign o_ds_req_data0 = w_d0;
  assign o_ds_req_data1 = w_d1;

  assign w_tag_in = '{valid: w_any, idx: w_gidx, local_err: w_local_err};

  if (CXU_LATENCY == 0) begin : g_lat0
    assign w_tag_out = w_tag_in;
  end else begin : g_pipe
    arb_tag_t r_tag [CXU_LATENCY];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int unsigned i = 0; i < CXU_LATENCY; i++) begin
          r_tag[i] <= '0;
        end
      end else if (i_clk_en) begin
        r_tag[0] <= w_tag_in;
        for (int unsigned i = 1; i < CXU_LATENCY; i++) begin
          r_tag[i] <= r_tag[i-1];
        end
      end
    end

    assign w_tag_out = r_tag[CXU_LATENCY-1];
  end

  always_comb begin
    o_resp_valid  = '0;
    o_resp_status = CXU_OK;
    o_resp_data   = '0;
    if (w_tag_out.valid) begin
      for (int unsigned i = 0; i < N_REQS; i++) begin
        if (32'(w_tag_out.idx) == i) begin
          o_resp_valid[i] = 1'b1;
        end
      end
      if (w_tag_out.local_err) begin
        o_resp_status = CXU_ERROR_STATE;
      end else begin
        o_resp_status = i_ds_resp_status;
        o_resp_data   = i_ds_resp_data;
      end
    end
  end

  // The downstream CXU must answer exactly when a forwarded request matures.
  assign w_ds_expect = w_tag_out.valid && !w_tag_out.local_err;

  a_ds_resp_sync : assert property (@(posedge i_clk) disable iff (i_rst || !i_clk_en)
    i_ds_resp_valid == w_ds_expect);

endmodule

// File: tb/tb_cxu_l1_arbiter.sv
// Directed bench for cxu_l1_arbiter with a small 2-cycle multiply-accumulate
// CXU standing in for the downstream unit.
module tb_cxu_l1_arbiter;
  import cxu_l1_arbiter_pkg::*;

  localparam int unsigned NR  = 4;
  localparam int unsigned NS  = 2;
  localparam int unsigned LAT = 2;
  localparam int unsigned FW  = 10;
  localparam int unsigned SW  = 2;
  localparam int unsigned DSW = 3;
  localparam int unsigned DW  = 32;

  localparam logic [FW-1:0] F_MUL    = 10'd0;
  localparam logic [FW-1:0] F_MULACC = 10'd1;

  logic              clk;
  logic              rst;
  logic              clk_en;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*FW-1:0]  req_func;
  logic [NR*SW-1:0]  req_state;
  logic [NR*DW-1:0]  req_data0;
  logic [NR*DW-1:0]  req_data1;
  logic [NR-1:0]     resp_valid;
  cxu_status_t       resp_status;
  logic [DW-1:0]     resp_data;
  logic              ds_req_valid;
  logic [FW-1:0]     ds_req_func;
  logic [DSW-1:0]    ds_req_state;
  logic [DW-1:0]     ds_req_data0;
  logic [DW-1:0]     ds_req_data1;
  logic              ds_resp_valid;
  cxu_status_t       ds_resp_status;
  logic [DW-1:0]     ds_resp_data;

  int checks   = 0;
  int failures = 0;

  cxu_l1_arbiter #(
    .N_REQS(NR), .N_STATES_PER(NS), .CXU_LATENCY(LAT), .CXU_FUNC_ID_W(FW),
    .CXU_STATE_ID_W(SW), .DS_STATE_ID_W(DSW), .CXU_DATA_W(DW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_func(req_func), .i_req_state(req_state),
    .i_req_data0(req_data0), .i_req_data1(req_data1),
    .o_resp_valid(resp_valid), .o_resp_status(resp_status), .o_resp_data(resp_data),
    .o_ds_req_valid(ds_req_valid), .o_ds_req_func(ds_req_func),
    .o_ds_req_state(ds_req_state), .o_ds_req_data0(ds_req_data0),
    .o_ds_req_data1(ds_req_data1),
    .i_ds_resp_valid(ds_resp_valid), .i_ds_resp_status(ds_resp_status),
    .i_ds_resp_data(ds_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream mulacc CXU: MUL returns a*b, MULACC accumulates into its state.
  logic [DW-1:0] m_acc [NR*NS];
  logic          m_v0, m_v1;
  logic [DW-1:0] m_d0, m_d1;
  logic [DW-1:0] m_res;

  assign m_res = ((ds_req_func == F_MULACC) ? m_acc[ds_req_state] : '0)
               + ds_req_data0 * ds_req_data1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NR*NS); i++) m_acc[i] <= '0;
      m_v0 <= 1'b0;
      m_v1 <= 1'b0;
      m_d0 <= '0;
      m_d1 <= '0;
    end else if (clk_en) begin
      if (ds_req_valid && ds_req_func == F_MULACC) m_acc[ds_req_state] <= m_res;
      m_v0 <= ds_req_valid;
      m_d0 <= m_res;
      m_v1 <= m_v0;
      m_d1 <= m_d0;
    end
  end

  assign ds_resp_valid  = m_v1;
  assign ds_resp_data   = m_v1 ? m_d1 : '0;
  assign ds_resp_status = CXU_OK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [FW-1:0] f, input logic [SW-1:0] s,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_func[r*FW +: FW]  = f;
    req_state[r*SW +: SW] = s;
    req_data0[r*DW +: DW] = a;
    req_data1[r*DW +: DW] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] fair_g [3];
    logic [DW-1:0] fair_d [3];
    logic [DSW-1:0] fair_s [3];
    fair_g = '{4'b0001, 4'b0010, 4'b1000};
    fair_d = '{32'd6, 32'd20, 32'd42};
    fair_s = '{3'd0, 3'd2, 3'd6};

    rst = 1'b1; clk_en = 1'b1; req_valid = '0;
    req_func = '0; req_state = '0; req_data0 = '0; req_data1 = '0;
    #12;
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_status", 64'(resp_status), 64'(CXU_OK));
    check("rst_resp_data", 64'(resp_data), 64'h0);
    check("rst_ds_valid", 64'(ds_req_valid), 64'h0);
    rst = 1'b0;
    tick();

    // Fairness: r0, r1, r3 contend for six cycles.
    set_req(0, F_MUL, 2'd0, 32'd2, 32'd3);
    set_req(1, F_MUL, 2'd0, 32'd4, 32'd5);
    set_req(3, F_MUL, 2'd0, 32'd6, 32'd7);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 6) ? 4'b1011 : 4'b0000;
      #1;
      if (c < 6) begin
        check($sformatf("fair_ready_%0d", c), 64'(req_ready), 64'(fair_g[c%3]));
        check($sformatf("fair_ds_state_%0d", c), 64'(ds_req_state), 64'(fair_s[c%3]));
      end
      if (c >= 2) begin
        check($sformatf("fair_resp_valid_%0d", c), 64'(resp_valid), 64'(fair_g[(c-2)%3]));
        check($sformatf("fair_resp_data_%0d", c), 64'(resp_data), 64'(fair_d[(c-2)%3]));
      end else begin
        check($sformatf("fair_resp_idle_%0d", c), 64'(resp_valid), 64'h0);
      end
      tick();
    end

    // Single requester: r2 mul 3*5 on its state 1.
    set_req(2, F_MUL, 2'd1, 32'd3, 32'd5);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(req_ready), 64'h4);
    check("single_ds_valid", 64'(ds_req_valid), 64'h1);
    check("single_ds_state", 64'(ds_req_state), 64'd5);
    check("single_ds_data0", 64'(ds_req_data0), 64'd3);
    tick();
    req_valid = '0;
    #1;
    check("single_resp_wait", 64'(resp_valid), 64'h0);
    tick();
    check("single_resp_valid", 64'(resp_valid), 64'h4);
    check("single_resp_data", 64'(resp_data), 64'd15);
    check("single_resp_status", 64'(resp_status), 64'(CXU_OK));
    tick();

    // Isolation: r0 and r1 each accumulate 2*2 three times on local state 0.
    set_req(0, F_MULACC, 2'd0, 32'd2, 32'd2);
    set_req(1, F_MULACC, 2'd0, 32'd2, 32'd2);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 6) ? 4'b0011 : 4'b0000;
      #1;
      if (c < 6) begin
        check($sformatf("iso_ready_%0d", c), 64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
        check($sformatf("iso_ds_state_%0d", c), 64'(ds_req_state), (c % 2 == 0) ? 64'd0 : 64'd2);
      end
      if (c >= 2) begin
        check($sformatf("iso_resp_valid_%0d", c), 64'(resp_valid),
              ((c - 2) % 2 == 0) ? 64'h1 : 64'h2);
        check($sformatf("iso_resp_data_%0d", c), 64'(resp_data), 64'(4 * ((c - 2) / 2 + 1)));
      end
      tick();
    end

    // Local error: r3 names private state 3, which does not exist.
    set_req(3, F_MUL, 2'd3, 32'd9, 32'd9);
    req_valid = 4'b1000;
    #1;
    check("lerr_ready", 64'(req_ready), 64'h8);
    check("lerr_ds_valid", 64'(ds_req_valid), 64'h0);
    tick();
    req_valid = '0;
    #1;
    check("lerr_resp_wait", 64'(resp_valid), 64'h0);
    tick();
    check("lerr_resp_valid", 64'(resp_valid), 64'h8);
    check("lerr_resp_status", 64'(resp_status), 64'(CXU_ERROR_STATE));
    check("lerr_resp_data", 64'(resp_data), 64'h0);
    tick();

    // Clock enable: r1 in flight, then three frozen cycles with r0 waiting.
    set_req(1, F_MUL, 2'd0, 32'd7, 32'd9);
    req_valid = 4'b0010;
    #1;
    check("cen_ready_r1", 64'(req_ready), 64'h2);
    tick();
    set_req(0, F_MUL, 2'd0, 32'd1, 32'd1);
    for (int c = 0; c < 3; c++) begin
      clk_en = 1'b0;
      req_valid = 4'b0001;
      #1;
      check($sformatf("cen_frozen_ready_%0d", c), 64'(req_ready), 64'h0);
      check($sformatf("cen_frozen_resp_%0d", c), 64'(resp_valid), 64'h0);
      tick();
    end
    clk_en = 1'b1;
    #1;
    check("cen_resume_ready_r0", 64'(req_ready), 64'h1);
    check("cen_resume_resp_wait", 64'(resp_valid), 64'h0);
    tick();
    req_valid = '0;
    #1;
    check("cen_resp_valid_r1", 64'(resp_valid), 64'h2);
    check("cen_resp_data_r1", 64'(resp_data), 64'd63);
    tick();
    check("cen_resp_valid_r0", 64'(resp_valid), 64'h1);
    check("cen_resp_data_r0", 64'(resp_data), 64'd1);
    tick();

    // Reset with two requests in flight.
    set_req(2, F_MUL, 2'd0, 32'd2, 32'd2);
    set_req(3, F_MUL, 2'd0, 32'd3, 32'd3);
    req_valid = 4'b1100;
    #1;
    check("rmid_ready_r2", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b1000;
    #1;
    check("rmid_ready_r3", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    #1;
    check("rmid_inflight_r2", 64'(resp_valid), 64'h4);
    #1;
    rst = 1'b1;
    #1;
    check("rmid_resp_cleared", 64'(resp_valid), 64'h0);
    check("rmid_data_cleared", 64'(resp_data), 64'h0);
    tick();
    check("rmid_resp_held", 64'(resp_valid), 64'h0);
    #2;
    rst = 1'b0;
    tick();
    check("rmid_no_stale_0", 64'(resp_valid), 64'h0);
    tick();
    check("rmid_no_stale_1", 64'(resp_valid), 64'h0);
    set_req(0, F_MUL, 2'd0, 32'd5, 32'd6);
    req_valid = 4'b1011;
    #1;
    check("rmid_first_grant_r0", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    tick();
    check("rmid_resp_valid_r0", 64'(resp_valid), 64'h1);
    check("rmid_resp_data_r0", 64'(resp_data), 64'd30);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
